// File: rtl/mic_fir_filter.sv
// ---------------------------------------------------------------------------
// mic_fir_filter
//
// Dual-channel (left/right) FIR stage for the microphone path. One sample
// pair is filtered at a time by a single multiply-accumulate per channel,
// stepping through the taps one per cycle. Coefficients live in two banks:
// the active bank feeds the MAC while the host refills the shadow bank, and
// a swap makes the freshly loaded bank active.
//
// Ports:
//   CLK            system clock
//   RESET          synchronous, active-high reset
//   sample_in      {left[31:16], right[15:0]}, signed 16-bit samples
//   sample_ready   1-cycle strobe, sample_in valid this cycle
//   coef_data      signed coefficient word for the shadow bank
//   load_coef      write coef_data at the shadow write pointer
//   change_filter  request to swap active and shadow banks
//   fir_left_data  filtered left, saturated to 16 bits, sign-extended
//   fir_right_data filtered right, same format
//   out_valid      1-cycle strobe, new fir_*_data this cycle
//   busy           high while a sample is being filtered
//   active_bank    index of the bank used for filtering
//   overrun        sticky, a sample arrived while busy and was dropped
// ---------------------------------------------------------------------------
module mic_fir_filter #(
    parameter int TAPS      = 16,
    parameter int COEF_FRAC = 15,
    parameter int ACC_W     = 40
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] sample_in,
    input  logic        sample_ready,
    input  logic [15:0] coef_data,
    input  logic        load_coef,
    input  logic        change_filter,
    output logic [31:0] fir_left_data,
    output logic [31:0] fir_right_data,
    output logic        out_valid,
    output logic        busy,
    output logic        active_bank,
    output logic        overrun
);

    localparam int            KW     = $clog2(TAPS);
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [KW-1:0] k_idx;
    logic [KW-1:0] wptr;
    logic          swap_pending;

    logic signed [15:0] hist_l  [TAPS];
    logic signed [15:0] hist_r  [TAPS];
    logic signed [15:0] coef_b0 [TAPS];
    logic signed [15:0] coef_b1 [TAPS];

    logic signed [ACC_W-1:0] acc_l;
    logic signed [ACC_W-1:0] acc_r;

    logic signed [15:0] coef_k;
    logic signed [31:0] prod_l;
    logic signed [31:0] prod_r;

    logic accept;
    logic drop;
    logic swap_now;
    logic swap_pending_next;

    // Scale back from Q-format and clamp to the signed 16-bit range.
    function automatic logic [31:0] scale_sat(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> COEF_FRAC;
        if (r > SAT_MAX)
            return 32'h0000_7FFF;
        else if (r < SAT_MIN)
            return 32'hFFFF_8000;
        else
            return {{16{r[15]}}, r[15:0]};
    endfunction

    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (sample_ready) state_next = S_MAC;
            S_MAC:   if (k_idx == K_LAST) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control decodes and the per-tap products
    // ------------------------------------------------------------------
    always_comb begin
        accept = (state == S_IDLE) && sample_ready;
        drop   = (state != S_IDLE) && sample_ready;

        // A swap is immediate only when the datapath is idle and no sample
        // is starting; otherwise it waits for the end of the current sample
        // so every tap of that sample sees the same bank.
        swap_now = ((state == S_IDLE) && change_filter && !sample_ready) ||
                   ((state == S_DONE) && (swap_pending || change_filter));

        swap_pending_next = swap_pending;
        if (swap_now)
            swap_pending_next = 1'b0;
        else if (change_filter)
            swap_pending_next = 1'b1;

        coef_k = active_bank ? coef_b1[k_idx] : coef_b0[k_idx];
        prod_l = 32'(hist_l[k_idx]) * 32'(coef_k);
        prod_r = 32'(hist_r[k_idx]) * 32'(coef_k);
    end

    // ------------------------------------------------------------------
    // State, datapath and coefficient storage
    // ------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_IDLE;
            k_idx          <= '0;
            wptr           <= '0;
            swap_pending   <= 1'b0;
            acc_l          <= '0;
            acc_r          <= '0;
            fir_left_data  <= '0;
            fir_right_data <= '0;
            out_valid      <= 1'b0;
            active_bank    <= 1'b0;
            overrun        <= 1'b0;
            // NOTE: the coefficient banks and history lines are cleared on
            // reset on purpose: a filter restarted after reset must not mix
            // in stale samples or taps from before it.
            for (int i = 0; i < TAPS; i++) begin
                hist_l[i]  <= '0;
                hist_r[i]  <= '0;
                coef_b0[i] <= '0;
                coef_b1[i] <= '0;
            end
        end else begin
            state        <= state_next;
            out_valid    <= (state == S_DONE);
            swap_pending <= swap_pending_next;

            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    hist_l[i] <= hist_l[i-1];
                    hist_r[i] <= hist_r[i-1];
                end
                hist_l[0] <= sample_in[31:16];
                hist_r[0] <= sample_in[15:0];
                acc_l     <= '0;
                acc_r     <= '0;
                k_idx     <= '0;
            end

            if (state == S_MAC) begin
                acc_l <= acc_l + ACC_W'(prod_l);
                acc_r <= acc_r + ACC_W'(prod_r);
                if (k_idx != K_LAST)
                    k_idx <= k_idx + 1'b1;
            end

            if (state == S_DONE) begin
                fir_left_data  <= scale_sat(acc_l);
                fir_right_data <= scale_sat(acc_r);
            end

            if (drop)
                overrun <= 1'b1;

            // The write targets the bank that is shadow before any swap in
            // this cycle, so a simultaneous load and swap publishes the word.
            if (load_coef) begin
                if (active_bank)
                    coef_b0[wptr] <= coef_data;
                else
                    coef_b1[wptr] <= coef_data;
            end

            if (swap_now) begin
                active_bank <= ~active_bank;
                wptr        <= '0;
            end else if (load_coef) begin
                wptr <= (wptr == K_LAST) ? '0 : wptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mic_fir_filter.sv
// ---------------------------------------------------------------------------
// tb_mic_fir_filter
//
// Directed bench for mic_fir_filter (TAPS=16, COEF_FRAC=15). Inputs are
// driven on the falling clock edge and outputs sampled on the falling edge.
// Expected values are hand-computed in the comments next to each step.
// ---------------------------------------------------------------------------
module tb_mic_fir_filter;

    localparam int TAPS = 16;
    localparam int LAT  = TAPS + 2;

    logic        CLK;
    logic        RESET;
    logic [31:0] sample_in;
    logic        sample_ready;
    logic [15:0] coef_data;
    logic        load_coef;
    logic        change_filter;
    logic [31:0] fir_left_data;
    logic [31:0] fir_right_data;
    logic        out_valid;
    logic        busy;
    logic        active_bank;
    logic        overrun;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int t_accept = 0;
    int ov_count = 0;
    int ov0;
    int lat;

    mic_fir_filter #(
        .TAPS      (TAPS),
        .COEF_FRAC (15),
        .ACC_W     (40)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .sample_in      (sample_in),
        .sample_ready   (sample_ready),
        .coef_data      (coef_data),
        .load_coef      (load_coef),
        .change_filter  (change_filter),
        .fir_left_data  (fir_left_data),
        .fir_right_data (fir_right_data),
        .out_valid      (out_valid),
        .busy           (busy),
        .active_bank    (active_bank),
        .overrun        (overrun)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (out_valid) ov_count <= ov_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_left"},   fir_left_data,  32'h0);
        check({pfx, "_right"},  fir_right_data, 32'h0);
        check({pfx, "_valid"},  32'(out_valid),   32'h0);
        check({pfx, "_busy"},   32'(busy),        32'h0);
        check({pfx, "_bank"},   32'(active_bank), 32'h0);
        check({pfx, "_ovr"},    32'(overrun),     32'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic pulse_sample(input logic [31:0] s);
        @(negedge CLK);
        sample_in    = s;
        sample_ready = 1'b1;
        t_accept     = cyc;
        @(negedge CLK);
        sample_ready = 1'b0;
    endtask

    // Returns cycles from the accepting cycle to out_valid, or -1 on timeout.
    task automatic wait_valid(output int l);
        l = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) begin
                l = cyc - t_accept;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic run_sample(input logic [31:0] s, output int l);
        pulse_sample(s);
        wait_valid(l);
    endtask

    task automatic load_word(input logic [15:0] c);
        @(negedge CLK);
        coef_data = c;
        load_coef = 1'b1;
        @(negedge CLK);
        load_coef = 1'b0;
    endtask

    task automatic change_now();
        @(negedge CLK);
        change_filter = 1'b1;
        @(negedge CLK);
        change_filter = 1'b0;
    endtask

    initial begin
        RESET         = 1'b1;
        sample_in     = '0;
        sample_ready  = 1'b0;
        coef_data     = '0;
        load_coef     = 1'b0;
        change_filter = 1'b0;

        // --- A: reset state, zero coefficients give zero output -----------
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check_all_zero("rst");

        pulse_sample(32'h1234_5678);
        check("a_busy", 32'(busy), 32'h1);
        wait_valid(lat);
        check("a_lat",   32'(lat), 32'(LAT));
        check("a_left",  fir_left_data,  32'h0);
        check("a_right", fir_right_data, 32'h0);

        // --- B: tap0 = 0.5, immediate swap in IDLE ------------------------
        load_word(16'h4000);
        repeat (15) load_word(16'h0000);
        change_now();
        check("b_bank", 32'(active_bank), 32'h1);
        // 1000*0.5 = 500 ; -2000*0.5 = -1000 = 0xFFFFFC18
        run_sample({16'd1000, 16'hF830}, lat);
        check("b_lat",   32'(lat), 32'(LAT));
        check("b_left",  fir_left_data,  32'd500);
        check("b_right", fir_right_data, 32'hFFFF_FC18);
        idle(3);
        check("b_hold",  fir_left_data,  32'd500);

        // --- C: mid-MAC load+swap, repeated swap request absorbed ---------
        pulse_sample({16'd1000, 16'd1000});
        @(negedge CLK);
        coef_data     = 16'h2000;
        load_coef     = 1'b1;
        change_filter = 1'b1;
        @(negedge CLK);
        load_coef     = 1'b0;
        change_filter = 1'b0;
        @(negedge CLK);
        change_filter = 1'b1;
        @(negedge CLK);
        change_filter = 1'b0;
        check("c_bank_mid", 32'(active_bank), 32'h1);
        wait_valid(lat);
        // In-flight sample still uses bank 1 (0.5): 500
        check("c_lat",   32'(lat), 32'(LAT));
        check("c_left",  fir_left_data,  32'd500);
        check("c_right", fir_right_data, 32'd500);
        check("c_bank",  32'(active_bank), 32'h0);
        // Bank 0 tap0 = 0.25: 1000 -> 250
        run_sample({16'd1000, 16'd1000}, lat);
        check("c2_lat",   32'(lat), 32'(LAT));
        check("c2_left",  fir_left_data,  32'd250);
        check("c2_right", fir_right_data, 32'd250);

        // --- D: dropped sample, history not shifted -----------------------
        // Bank 1 becomes a delta at tap1 with gain 0.5.
        load_word(16'h0000);
        load_word(16'h4000);
        repeat (14) load_word(16'h0000);
        change_now();
        check("d_bank",   32'(active_bank), 32'h1);
        check("d_ovr0",   32'(overrun), 32'h0);
        idle(2);
        ov0 = ov_count;
        pulse_sample({16'd2000, 16'd2000});
        @(negedge CLK);
        @(negedge CLK);
        sample_in    = {16'd7000, 16'd7000};
        sample_ready = 1'b1;
        @(negedge CLK);
        sample_ready = 1'b0;
        check("d_ovr1",   32'(overrun), 32'h1);
        wait_valid(lat);
        // hist[1] is the previous 1000 -> 500
        check("d_lat",    32'(lat), 32'(LAT));
        check("d_left",   fir_left_data,  32'd500);
        check("d_right",  fir_right_data, 32'd500);
        idle(25);
        check("d_nvalid", 32'(ov_count), 32'(ov0 + 1));
        // hist[1] must be 2000 (not the dropped 7000) -> 1000
        run_sample({16'd4000, 16'd4000}, lat);
        check("d2_left",  fir_left_data,  32'd1000);
        check("d2_right", fir_right_data, 32'd1000);

        // --- E: saturation, all taps 0x7FFF -------------------------------
        repeat (16) load_word(16'h7FFF);
        change_now();
        check("e_bank", 32'(active_bank), 32'h0);
        for (int i = 0; i < 16; i++)
            run_sample({16'h7FFF, 16'h8000}, lat);
        check("e_lat",   32'(lat), 32'(LAT));
        check("e_left",  fir_left_data,  32'h0000_7FFF);
        check("e_right", fir_right_data, 32'hFFFF_8000);
        check("e_ovr",   32'(overrun), 32'h1);

        // --- F: reset clears everything; 17 writes wrap the pointer -------
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        check_all_zero("rst2");

        for (int v = 1; v <= 17; v++)
            load_word(16'(v));
        change_now();
        check("f_bank", 32'(active_bank), 32'h1);
        // Taps: 17,2,3,...,16. Left -32768*c>>>15 = -c ; right 32767*c>>>15 = c-1
        run_sample({16'h8000, 16'h7FFF}, lat);
        check("f_lat",    32'(lat), 32'(LAT));
        check("f_t0_l",   fir_left_data,  32'hFFFF_FFEF);
        check("f_t0_r",   fir_right_data, 32'h0000_0010);
        run_sample(32'h0, lat);
        check("f_t1_l",   fir_left_data,  32'hFFFF_FFFE);
        check("f_t1_r",   fir_right_data, 32'h0000_0001);
        repeat (14) run_sample(32'h0, lat);
        check("f_t15_l",  fir_left_data,  32'hFFFF_FFF0);
        check("f_t15_r",  fir_right_data, 32'h0000_000F);

        // Reset mid-MAC: no out_valid, everything back to zero.
        idle(2);
        ov0 = ov_count;
        pulse_sample({16'd100, 16'd100});
        @(negedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        idle(30);
        check("g_nvalid", 32'(ov_count), 32'(ov0));
        check_all_zero("rst3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mic_fir_filter.md
Name: mic_fir_filter

Overview:
- Dual-channel FIR stage directly downstream of the Avalon microphone system.
- Consumes the system's coefficient stream (`coef_data`, `load_coef`, `change_filter`), its `sample_ready` strobe and a packed {left,right} 16-bit sample word.
- Produces filtered left/right samples on the `fir_left_data`/`fir_right_data` buses, which return to the system for the codec/DMA path.
- Holds double-buffered coefficient banks, so the host can reload taps while filtering continues.

Parameters:
- TAPS, 16, number of filter taps per channel (2..64).
- COEF_FRAC, 15, fractional bits of Q-format coefficients; accumulator is arithmetically right-shifted by this amount.
- ACC_W, 40, accumulator width in bits.

Ports:
- CLK  in  1  system clock; single clock domain.
- RESET  in  1  synchronous, active-high reset.
- sample_in  in  32  {left[31:16], right[15:0]}, signed 16-bit samples.
- sample_ready  in  1  1-cycle strobe: sample_in valid this cycle.
- coef_data  in  16  signed coefficient word.
- load_coef  in  1  write coef_data into the shadow bank at the write pointer.
- change_filter  in  1  request to swap active and shadow banks.
- fir_left_data  out  32  filtered left, saturated to signed 16 and sign-extended.
- fir_right_data  out  32  filtered right, same format.
- out_valid  out  1  1-cycle strobe: new fir_*_data this cycle.
- busy  out  1  high while in MAC or DONE.
- active_bank  out  1  index of the bank currently used for filtering.
- overrun  out  1  sticky; set when a sample_ready is dropped.

Behaviour:
- Reset (synchronous, active-high, CLK rising edge):
  - Both coefficient banks and both history lines are cleared to 0.
  - Write pointer = 0, state = IDLE, swap_pending = 0.
  - All outputs are 0: fir_left_data, fir_right_data, out_valid, busy, active_bank, overrun.
  - Reset asserted mid-MAC aborts the computation and no out_valid is produced.
- History:
  - Per channel, a TAPS-deep shift line; hist[0] is the newest sample.
  - On an accepted sample_ready, hist[k] <= hist[k-1] and hist[0] <= the new sample.
- FSM IDLE:
  - If sample_ready is high: shift history, clear both accumulators, index k = 0, go to MAC.
- FSM MAC:
  - Each cycle: acc_ch += hist_ch[k] * coef_active[k], using a signed 16x16 -> 32 product sign-extended to ACC_W.
  - Both channels are computed in parallel.
  - When k == TAPS-1, go to DONE; otherwise k++.
  - Takes exactly TAPS cycles.
- FSM DONE:
  - r = acc >>> COEF_FRAC (arithmetic shift).
  - Saturate r to [-32768, 32767]; sign-extend to 32 bits into fir_*_data.
  - out_valid = 1 for this one cycle, then return to IDLE.
  - fir_*_data holds its value until the next DONE.
- Latency: out_valid is asserted exactly TAPS+2 cycles after the cycle in which sample_ready was sampled high.
- sample_ready while busy:
  - The sample is ignored: no history shift, computation unaffected.
  - overrun <= 1; it is cleared only by RESET.
- load_coef:
  - shadow[wptr] <= coef_data; wptr <= (wptr == TAPS-1) ? 0 : wptr+1.
  - Legal in any state; it never touches the active bank.
- change_filter:
  - In IDLE with no sample_ready: swap in the same cycle (active_bank toggles, wptr <= 0).
  - Otherwise swap_pending <= 1 and the swap is performed in the DONE cycle. The in-flight sample uses the old bank for all taps.
  - A repeated change_filter while already pending is absorbed: one swap only.
- Simultaneous load_coef and change_filter in one cycle:
  - The write lands in the current shadow bank first, then the swap applies.
  - The written word therefore becomes part of the new active bank.
- Simultaneous sample_ready and change_filter in IDLE:
  - The sample is accepted using the old bank; the swap is deferred to DONE.

Test Plan:
1. Assert RESET 2 cycles, release -> all outputs 0, active_bank=0, busy=0; feed sample_ready with sample_in=32'h12345678 -> out_valid at +TAPS+2 with fir_left_data=fir_right_data=0 (zero coefficients).
2. Load 16 words (tap0=16'h4000, rest 0), pulse change_filter, then sample_in={16'sd1000,-16'sd2000} -> out_valid at +18 cycles; fir_left_data=32'd500, fir_right_data=32'hFFFFFC18; active_bank=1.
3. Load all taps 16'h7FFF and swap; feed 16 samples {16'h7FFF,16'h8000} -> 16th output gives fir_left_data=32'h00007FFF and fir_right_data=32'hFFFF8000 (saturated).
4. With bank 1 at tap0=16'h4000, start a sample; mid-MAC load tap0=16'h2000 and pulse change_filter -> that output uses 0.5 gain; active_bank toggles in the DONE cycle; the next sample of 1000 yields 250.
5. Pulse sample_ready at +3 cycles after an accepted sample -> no extra out_valid, overrun=1, and history is unshifted (verify with a delta-tap bank on the next output).
6. Issue 17 load_coef writes (values 1..17) then swap -> tap0=17, taps 1..15 = 2..16; RESET mid-MAC -> no out_valid, all outputs 0.
